// File: rtl/fetch_sequencer.sv
// Fetch-stage PC and instruction-memory request controller.
// Latency: start -> imem_req_o after one edge; imem_ack_i -> instr_valid_o after one edge.
// Backpressure: stall_i holds the issued instruction and PC in ISSUE; one request outstanding.
//
// Ports:
//   clk_i, rst_ni              clock (rising edge) and asynchronous active-low reset
//   start_i                    begin fetching (sampled only in IDLE)
//   stall_i                    decode not ready; hold current instruction
//   branch_taken_i/target_i    redirect request, sampled in ISSUE when not stalled
//   imem_req_o/addr_o          memory request (held until ack) and its address (== pc_o)
//   imem_ack_i/data_i          memory response
//   instr_o, instr_valid_o     registered instruction presented to decode
//   pc_o                       address of the current or pending instruction
//   fault_o                    sticky error flag (timeout or misaligned branch)

module fetch_sequencer #(
   parameter int              WORD     = 64,
   parameter logic [WORD-1:0] RESET_PC = '0,
   parameter int              TIMEOUT  = 8
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic            stall_i,
   input  logic            branch_taken_i,
   input  logic [WORD-1:0] branch_target_i,
   output logic            imem_req_o,
   output logic [WORD-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [31:0]     imem_data_i,
   output logic [31:0]     instr_o,
   output logic            instr_valid_o,
   output logic [WORD-1:0] pc_o,
   output logic            fault_o
);

   // Counter only needs to hold 0..TIMEOUT-1: the TIMEOUT-th miss faults instead of counting.
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [WORD-1:0] pc_q, pc_d;
   logic [31:0]     instr_q, instr_d;
   logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d    = S_FETCH;
               wait_cnt_d = '0;
            end
         end
         S_FETCH: begin
            // Ack wins over timeout, even on the last permitted cycle.
            if (imem_ack_i) begin
               instr_d = imem_data_i;
               state_d = S_ISSUE;
            end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
               state_d = S_FAULT;
            end else begin
               wait_cnt_d = wait_cnt_q + CW'(1);
            end
         end
         S_ISSUE: begin
            if (!stall_i) begin
               wait_cnt_d = '0;
               if (branch_taken_i) begin
                  // The bad target is kept in pc for post-mortem inspection.
                  pc_d    = branch_target_i;
                  state_d = (branch_target_i[1:0] != 2'b00) ? S_FAULT : S_FETCH;
               end else begin
                  pc_d    = pc_q + WORD'(4);
                  state_d = S_FETCH;
               end
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign imem_req_o    = (state_q == S_FETCH);
   assign instr_valid_o = (state_q == S_ISSUE);
   assign fault_o       = (state_q == S_FAULT);
   assign imem_addr_o   = pc_q;
   assign pc_o          = pc_q;
   assign instr_o       = instr_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller for the fetch-stage program counter register and the instruction-memory port.
- Owns the 64-bit PC and issues one instruction-memory request at a time.
- Presents each fetched instruction to decode with a valid/stall handshake, and redirects the PC on taken branches.
- Traps to a sticky fault state on memory timeout or a misaligned branch target.

Parameters:
- WORD, 64, datapath/PC width in bits.
- RESET_PC, 64'h0, PC value loaded on reset.
- TIMEOUT, 8, max FETCH cycles without imem_ack before fault (>=1).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin fetching; sampled only in IDLE.
- stall  input  1  decode not ready; holds the current instruction.
- branch_taken  input  1  redirect request; sampled only in ISSUE when stall=0.
- branch_target  input  WORD  redirect address.
- imem_req  output  1  memory request, held until ack.
- imem_addr  output  WORD  request address; always equals pc.
- imem_ack  input  1  memory data valid this cycle.
- imem_data  input  32  instruction word.
- instr  output  32  registered instruction.
- instr_valid  output  1  instr valid for decode.
- pc  output  WORD  address of the current or pending instruction.
- fault  output  1  sticky error flag.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values, applied immediately while reset=0:
  - state=IDLE, pc=RESET_PC, imem_req=0, instr=0, instr_valid=0, fault=0, wait_cnt=0.
  - Any in-flight fetch is discarded; a later ack is ignored.
- States: IDLE, FETCH, ISSUE, FAULT. Outputs are Moore, decoded from registered state:
  - imem_req=1 only in FETCH.
  - instr_valid=1 only in ISSUE.
  - fault=1 only in FAULT.
- IDLE: start=1 -> FETCH at the next edge, with wait_cnt=0. Otherwise remain in IDLE.
- FETCH:
  - imem_req=1; imem_addr=pc, stable for the whole request.
  - imem_ack=1 -> instr<=imem_data, go to ISSUE.
  - imem_ack=0 -> wait_cnt+1. If this is the TIMEOUT-th consecutive cycle without ack, go to FAULT.
  - An ack in the TIMEOUT-th cycle is accepted; ack has priority over timeout.
  - branch_taken is ignored in FETCH.
- ISSUE:
  - stall=1: remain in ISSUE; instr and pc held; branch_taken ignored.
  - stall=0 with branch_taken=1 and branch_target[1:0]!=0: go to FAULT; pc<=branch_target (records the bad address).
  - stall=0 with branch_taken=1 and aligned target: pc<=branch_target, go to FETCH, wait_cnt=0.
  - stall=0 with branch_taken=0: pc<=pc+4, go to FETCH, wait_cnt=0.
- FAULT: absorbing. Exit only via reset; all inputs are ignored.
- imem_ack outside FETCH is ignored; instr does not change.
- Arithmetic: pc+4 is modulo 2^WORD; 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0 with no fault.
- Latency:
  - start at edge N -> imem_req high after N.
  - Ack sampled at edge N+k -> instr_valid high after N+k.
  - Minimum throughput: 2 cycles per instruction (FETCH + ISSUE).
- instr holds its last value in IDLE and FAULT.

Test Plan:
- Reset/start: hold reset=0 -> imem_req=0, instr_valid=0, pc=0, fault=0. Release reset, pulse start -> next cycle imem_req=1, imem_addr=0. Drive ack with imem_data=32'h8B020020 -> next cycle instr_valid=1, instr=32'h8B020020.
- Sequential fetch with stall:
  - stall=1 for 3 cycles in ISSUE -> instr_valid, instr, and pc=0 stay constant.
  - Drop stall -> FETCH at pc=4. Ack after 2 wait cycles -> ISSUE, pc=4.
- Branch:
  - ISSUE at pc=8, stall=0, branch_taken=1, branch_target=64'h400 -> imem_addr=64'h400.
  - Branch asserted during FETCH -> ignored; the next PC is pc+4.
- Misaligned branch: branch_target=64'h402 in ISSUE with stall=0 -> fault=1, pc=64'h402, imem_req=0. Further start/ack pulses cause no change.
- Timeout (TIMEOUT=8):
  - No ack for 8 FETCH cycles -> fault=1 after the 8th edge.
  - Repeat with ack in exactly the 8th cycle -> ISSUE, fault=0.
- Wrap and async reset:
  - RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, ack, stall=0 -> imem_addr=0.
  - Assert reset mid-FETCH, between clock edges -> imem_req drops immediately, pc=RESET_PC. An ack arriving after reset release has no effect in IDLE.
